// File: rtl/mem_ctrl_if.sv
// Bus bundle between mem_ctrl, its two requesters and the byte-wide RAM/IO port.
// The slave modport is the controller's view; master is the surrounding system.
interface mem_ctrl_if #(
    parameter int IC_BYTES = 4
);
    logic                    ic_req;
    logic [31:0]             ic_addr;
    logic                    ic_valid;
    logic [8*IC_BYTES-1:0]   ic_dout;

    logic                    lsb_enable;
    logic                    lsb_wr;
    logic [31:0]             lsb_addr;
    logic [31:0]             lsb_din;
    logic [2:0]              lsb_len;
    logic                    lsb_valid;
    logic [31:0]             lsb_dout;

    logic [7:0]              mem_din;
    logic [7:0]              mem_dout;
    logic [31:0]             mem_a;
    logic                    mem_wr;
    logic                    io_buffer_full;

    modport slave (
        input  ic_req, ic_addr,
        input  lsb_enable, lsb_wr, lsb_addr, lsb_din, lsb_len,
        input  mem_din, io_buffer_full,
        output ic_valid, ic_dout, lsb_valid, lsb_dout,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output ic_req, ic_addr,
        output lsb_enable, lsb_wr, lsb_addr, lsb_din, lsb_len,
        output mem_din, io_buffer_full,
        input  ic_valid, ic_dout, lsb_valid, lsb_dout,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO port owner: round-robin between fetch and load/store,
// little-endian byte assembly and a one-cycle done pulse per transaction.
module mem_ctrl #(
    parameter int         IC_BYTES  = 4,
    parameter logic [1:0] IO_PREFIX = 2'b11
) (
    input logic       clk,
    input logic       rst_n,
    input logic       rdy,
    input logic       rollback,
    mem_ctrl_if.slave bus
);
    localparam int CW = $clog2(IC_BYTES) + 1;
    localparam int BW = 8 * IC_BYTES;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx, len, lsb_n, idx;
    logic [BW-1:0]   rbuf, rbuf_nx;
    logic [31:0]     base, wdata;
    logic            owner_lsb, last_lsb, rw;
    logic            ic_valid_q, lsb_valid_q;
    logic [BW-1:0]   ic_dout_q;
    logic [31:0]     lsb_dout_q;
    logic            cand_ic, cand_lsb;
    logic            grant_ic, grant_lsb;
    logic            done, io_stall, abort;
    logic [31:0]     mem_a_c;
    logic [7:0]      mem_dout_c;
    logic            mem_wr_c;

    assign bus.ic_valid  = ic_valid_q;
    assign bus.ic_dout   = ic_dout_q;
    assign bus.lsb_valid = lsb_valid_q;
    assign bus.lsb_dout  = lsb_dout_q;
    assign bus.mem_a     = mem_a_c;
    assign bus.mem_dout  = mem_dout_c;
    assign bus.mem_wr    = mem_wr_c;

    always_comb begin
        case (bus.lsb_len)
            3'd1:    lsb_n = CW'(1);
            3'd2:    lsb_n = CW'(2);
            default: lsb_n = CW'(4);
        endcase
    end

    assign cand_ic  = bus.ic_req && !rollback;
    assign cand_lsb = bus.lsb_enable;
    assign io_stall = (base[17:16] == IO_PREFIX) && bus.io_buffer_full;
    assign abort    = !owner_lsb && rollback;
    assign idx      = cnt - CW'(1);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        rbuf_nx    = rbuf;
        grant_ic   = 1'b0;
        grant_lsb  = 1'b0;
        done       = 1'b0;
        mem_a_c    = 32'h0;
        mem_dout_c = 8'h0;
        mem_wr_c   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx  = '0;
                rbuf_nx = '0;
                // hold off while a pulse is out so the held request is not re-taken
                if (!ic_valid_q && !lsb_valid_q) begin
                    grant_lsb = cand_lsb && (!cand_ic || !last_lsb);
                    grant_ic  = cand_ic && !grant_lsb;
                    if (grant_lsb)
                        state_nx = bus.lsb_wr ? WRITE : READ;
                    else if (grant_ic)
                        state_nx = READ;
                end
            end
            READ: begin
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    if (cnt != len)
                        mem_a_c = base + 32'(cnt);
                    if (cnt != '0)
                        rbuf_nx[{idx, 3'b000} +: 8] = bus.mem_din;
                    cnt_nx = cnt + CW'(1);
                    if (cnt == len) begin
                        done     = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            WRITE: begin
                if (!io_stall) begin
                    mem_a_c    = base + 32'(cnt);
                    mem_dout_c = wdata[{cnt[1:0], 3'b000} +: 8];
                    mem_wr_c   = 1'b1;
                    cnt_nx     = cnt + CW'(1);
                    if (cnt == len - CW'(1)) begin
                        done     = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            len         <= '0;
            rbuf        <= '0;
            base        <= 32'h0;
            wdata       <= 32'h0;
            owner_lsb   <= 1'b0;
            last_lsb    <= 1'b0;
            rw          <= 1'b0;
            ic_valid_q  <= 1'b0;
            lsb_valid_q <= 1'b0;
            ic_dout_q   <= '0;
            lsb_dout_q  <= 32'h0;
        end else if (rdy) begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            rbuf        <= rbuf_nx;
            ic_valid_q  <= 1'b0;
            lsb_valid_q <= 1'b0;
            if (grant_lsb || grant_ic) begin
                owner_lsb <= grant_lsb;
                last_lsb  <= grant_lsb;
                base      <= grant_lsb ? bus.lsb_addr : bus.ic_addr;
                len       <= grant_lsb ? lsb_n : CW'(IC_BYTES);
                wdata     <= bus.lsb_din;
                rw        <= grant_lsb && bus.lsb_wr;
            end
            if (done) begin
                if (owner_lsb) begin
                    lsb_valid_q <= 1'b1;
                    if (!rw)
                        lsb_dout_q <= rbuf_nx[31:0];
                end else begin
                    ic_valid_q <= 1'b1;
                    ic_dout_q  <= rbuf_nx;
                end
            end
        end
    end
endmodule
